word_ctrl: RTL and testbench

- Sequencing controller for the word-count datapath of the Am2940-style DMA generator.
- Decodes host instructions into the word register and word counter strobes: plwr, selw, plwc, enw, incw and wci.
- Steps the counter once per accepted transfer request, detects terminal count for the selected mode, and reports done and busy to the top-level DMA FSM.

---
 rtl/word_ctrl_pkg.sv | 30 +++
 rtl/word_term_detect.sv | 34 +++
 rtl/word_ctrl.sv | 139 +++++++++++++
 tb/tb_word_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/word_ctrl_pkg.sv
// Shared encodings for the word-count sequencing controller.
package word_ctrl_pkg;

  localparam int unsigned WORD_W  = 4;
  localparam int unsigned INSTR_W = 3;
  localparam int unsigned MODE_W  = 2;

  typedef enum logic [INSTR_W-1:0] {
    I_NOP       = 3'b000,
    I_LOAD_WREG = 3'b001,
    I_LOAD_WCNT = 3'b010,
    I_REINIT    = 3'b011,
    I_START     = 3'b100,
    I_STOP      = 3'b101
  } instr_e;

  typedef enum logic [MODE_W-1:0] {
    M_DOWN   = 2'b00,
    M_UP_CMP = 2'b01,
    M_UP_OVF = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/word_term_detect.sv
// Terminal-count and zero-length detection for the word counter.
module word_term_detect
  import word_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  mode_e            i_mode,
  input  mode_e            i_start_mode,
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_wreg,
  output logic             o_term_c,
  output logic             o_zero_c
);

  logic [WIDTH-1:0] w_count_inc;

  assign w_count_inc = WIDTH'(i_count + WIDTH'(1));

  // Terminal when the transfer in progress is the last one for the running mode.
  always_comb begin
    o_term_c = 1'b0;
    case (i_mode)
      M_DOWN:   o_term_c = (i_count == WIDTH'(1));
      M_UP_CMP: o_term_c = (w_count_inc == i_wreg);
      M_UP_OVF: o_term_c = (i_count == {WIDTH{1'b1}});
      default:  o_term_c = 1'b0;
    endcase
  end

  // A start in this mode would have nothing to transfer.
  assign o_zero_c = ((i_start_mode == M_DOWN)   && (i_count == '0)) ||
                    ((i_start_mode == M_UP_CMP) && (i_count == i_wreg));

endmodule

// File: rtl/word_ctrl.sv
// Word-count sequencing controller for the DMA generator.
// Optional: WORD_CTRL_AUTOREINIT_EN makes DONE reload the counter and resume RUN.
module word_ctrl
  import word_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic [2:0]       instr,
  input  logic             instr_stb,
  input  logic [1:0]       cr_mode,
  input  logic             dma_req,
  input  logic [WIDTH-1:0] word_count_in,
  input  logic [WIDTH-1:0] word_reg_in,
  output logic             plwr,
  output logic             selw,
  output logic             plwc,
  output logic             enw,
  output logic             incw,
  output logic             wci,
  output logic             xfer_ack,
  output logic             busy,
  output logic             done
);

  state_e r_state;
  mode_e  r_mode;
  logic   r_xfer_ack;
  logic   r_done;

  logic w_instr_act;
  logic w_start;
  logic w_stop;
  logic w_reinit;
  logic w_term;
  logic w_zero;
  logic w_enw;

  assign w_instr_act = instr_stb & (instr != I_NOP);
  assign w_start     = instr_stb & (instr == I_START);
  assign w_stop      = instr_stb & (instr == I_STOP);
  assign w_reinit    = instr_stb & (instr == I_REINIT);

  word_term_detect #(.WIDTH(WIDTH)) u_term (
    .i_mode       (r_mode),
    .i_start_mode (mode_e'(cr_mode)),
    .i_count      (word_count_in),
    .i_wreg       (word_reg_in),
    .o_term_c     (w_term),
    .o_zero_c     (w_zero)
  );

  // Datapath strobes, held low while reset is asserted.
  always_comb begin
    plwr  = 1'b0;
    plwc  = 1'b0;
    selw  = 1'b0;
    w_enw = 1'b0;
    if (res) begin
      if (instr_stb && (instr == I_LOAD_WREG)) plwr = 1'b1;
      if (instr_stb && (instr == I_LOAD_WCNT)) plwc = 1'b1;
      if (w_reinit) begin
        plwc = 1'b1;
        selw = 1'b1;
      end
`ifdef WORD_CTRL_AUTOREINIT_EN
      if ((r_state == S_DONE) && !w_stop) begin
        plwc = 1'b1;
        selw = 1'b1;
      end
`endif
      w_enw = (r_state == S_RUN) & dma_req & (r_mode != M_HOLD) & ~w_instr_act;
    end
  end

  assign enw      = w_enw;
  assign wci      = w_enw;
  assign incw     = (r_mode != M_DOWN);
  assign busy     = (r_state == S_RUN);
  assign xfer_ack = r_xfer_ack;
  assign done     = r_done;

  // Controller state, latched mode and registered status flags.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= S_IDLE;
      r_mode     <= M_DOWN;
      r_xfer_ack <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_xfer_ack <= w_enw;
      r_done     <= 1'b0;
      if (w_stop) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_mode <= mode_e'(cr_mode);
              if (w_zero) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (w_enw && w_term) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_DONE: begin
            if (w_reinit) begin
              r_state <= S_IDLE;
            end else if (w_start) begin
              r_mode <= mode_e'(cr_mode);
              if (w_zero) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_RUN;
              end
            end else begin
`ifdef WORD_CTRL_AUTOREINIT_EN
              r_state <= S_RUN;
`else
              r_done  <= 1'b1;
`endif
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_word_ctrl.sv
// Randomized self-checking bench for word_ctrl with a behavioural reference model.
module tb_word_ctrl;

  logic       clk;
  logic       res;
  logic [2:0] instr;
  logic       instr_stb;
  logic [1:0] cr_mode;
  logic       dma_req;
  logic [3:0] word_count_in;
  logic [3:0] word_reg_in;
  logic       plwr, selw, plwc, enw, incw, wci, xfer_ack, busy, done;

  // Bench-side datapath and controller model
  logic [3:0] bus;
  logic [3:0] m_cnt, m_wreg;
  int         m_st;          // 0 idle, 1 run, 2 done
  logic [1:0] m_mode;
  logic       m_xack, m_done;
  logic       e_plwr, e_plwc, e_selw, e_enw, e_incw;

  int errors = 0;
  int checks = 0;
  int enw_seen = 0;

  assign word_count_in = m_cnt;
  assign word_reg_in   = m_wreg;

  word_ctrl #(.WIDTH(4)) dut (
    .clk           (clk),
    .res           (res),
    .instr         (instr),
    .instr_stb     (instr_stb),
    .cr_mode       (cr_mode),
    .dma_req       (dma_req),
    .word_count_in (word_count_in),
    .word_reg_in   (word_reg_in),
    .plwr          (plwr),
    .selw          (selw),
    .plwc          (plwc),
    .enw           (enw),
    .incw          (incw),
    .wci           (wci),
    .xfer_ack      (xfer_ack),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_mode = 2'b00; m_xack = 1'b0; m_done = 1'b0;
    m_cnt = 4'h0; m_wreg = 4'h0;
  endtask

  // Expected strobes for the current cycle from model state and inputs
  task automatic model_comb();
    logic nn, stop;
    nn   = instr_stb && (instr != 3'd0);
    stop = instr_stb && (instr == 3'd5);
    e_plwr = instr_stb && (instr == 3'd1);
    e_plwc = instr_stb && ((instr == 3'd2) || (instr == 3'd3));
    e_selw = instr_stb && (instr == 3'd3);
`ifdef WORD_CTRL_AUTOREINIT_EN
    if (m_st == 2 && !stop) begin
      e_plwc = 1'b1;
      e_selw = 1'b1;
    end
`endif
    e_enw  = (m_st == 1) && dma_req && (m_mode != 2'b11) && !nn;
    e_incw = (m_mode != 2'b00);
  endtask

  function automatic bit start_empty(input logic [1:0] md, input logic [3:0] c, input logic [3:0] w);
    return (md == 2'b00 && c == 4'd0) || (md == 2'b01 && c == w);
  endfunction

  // Advance model by one clock edge
  task automatic model_seq();
    logic [3:0] old_w, old_c;
    bit term, start, stop, reinit;
    int nst;
    old_w = m_wreg; old_c = m_cnt;
    case (m_mode)
      2'b00:   term = (old_c == 4'd1);
      2'b01:   term = (((int'(old_c) + 1) % 16) == int'(old_w));
      2'b10:   term = (old_c == 4'd15);
      default: term = 1'b0;
    endcase
    start  = instr_stb && instr == 3'd4;
    stop   = instr_stb && instr == 3'd5;
    reinit = instr_stb && instr == 3'd3;
    if (e_plwr) m_wreg = bus;
    if (e_plwc) m_cnt = e_selw ? old_w : bus;
    else if (e_enw) m_cnt = e_incw ? old_c + 4'd1 : old_c - 4'd1;
    m_xack = e_enw;
    nst = m_st;
    if (stop) nst = 0;
    else if (m_st == 1) begin
      if (e_enw && term) nst = 2;
    end else if (m_st == 2 && reinit) nst = 0;
    else if (start) begin
      m_mode = cr_mode;
      nst = start_empty(cr_mode, old_c, old_w) ? 2 : 1;
    end else if (m_st == 2) begin
`ifdef WORD_CTRL_AUTOREINIT_EN
      nst = 1;
`else
      nst = 2;
`endif
    end
    m_st = nst;
    m_done = (nst == 2);
  endtask

  task automatic cycle(input logic stb, input logic [2:0] ins, input logic [1:0] crm,
                       input logic req, input logic [3:0] b);
    @(negedge clk);
    instr_stb = stb; instr = ins; cr_mode = crm; dma_req = req; bus = b;
    #1;
    model_comb();
    check("plwr", plwr, e_plwr);
    check("plwc", plwc, e_plwc);
    if (e_plwc) check("selw", selw, e_selw);
    check("enw", enw, e_enw);
    check("wci", wci, e_enw);
    check("incw", incw, e_incw);
    check("xfer_ack", xfer_ack, m_xack);
    check("busy", busy, m_st == 1);
    check("done", done, m_done);
    if (enw) enw_seen++;
    @(posedge clk);
    #1;
    model_seq();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    instr_stb = 1'b1; instr = 3'd1; dma_req = 1'b1;
    #1;
    res = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_xack", xfer_ack, 0);
    check("rst_strobes", {plwr, plwc, enw, wci, incw}, 0);
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    instr_stb = 1'b0; instr = 3'd0;
    res = 1'b1;
  endtask

  initial begin
    res = 1'b0; instr = 3'd0; instr_stb = 1'b0; cr_mode = 2'b00; dma_req = 1'b0; bus = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_xack", xfer_ack, 0);
    check("reset_strobes", {plwr, selw, plwc, enw, incw, wci}, 0);
    @(negedge clk);
    res = 1'b1;

    // Down count from 3
    cycle(1, 3'd1, 2'b00, 0, 4'h3);
    cycle(1, 3'd3, 2'b00, 0, 4'h0);
    cycle(1, 3'd4, 2'b00, 0, 4'h0);
    enw_seen = 0;
    repeat (6) cycle(0, 3'd0, 2'b00, 1, 4'h0);
`ifndef WORD_CTRL_AUTOREINIT_EN
    check("t1_enw_count", enw_seen, 3);
    check("t1_done", done, 1);
`endif
    cycle(1, 3'd5, 2'b00, 0, 4'h0);

    // Up-compare to 5 with toggling request
    cycle(1, 3'd2, 2'b00, 0, 4'h0);
    cycle(1, 3'd1, 2'b00, 0, 4'h5);
    cycle(1, 3'd4, 2'b01, 0, 4'h0);
    enw_seen = 0;
    for (int i = 0; i < 14; i++) cycle(0, 3'd0, 2'b01, (i % 2) == 0, 4'h0);
`ifndef WORD_CTRL_AUTOREINIT_EN
    check("t2_enw_count", enw_seen, 5);
    check("t2_done", done, 1);
`endif
    cycle(1, 3'd5, 2'b00, 0, 4'h0);

    // Overflow mode from E
    cycle(1, 3'd2, 2'b00, 0, 4'hE);
    cycle(1, 3'd4, 2'b10, 0, 4'h0);
    enw_seen = 0;
    repeat (4) cycle(0, 3'd0, 2'b10, 1, 4'h0);
`ifndef WORD_CTRL_AUTOREINIT_EN
    check("t3_enw_count", enw_seen, 2);
    check("t3_done", done, 1);
`endif
    cycle(1, 3'd5, 2'b00, 0, 4'h0);

    // Zero-length start
    cycle(1, 3'd2, 2'b00, 0, 4'h0);
    cycle(1, 3'd4, 2'b00, 0, 4'h0);
    enw_seen = 0;
    repeat (3) cycle(0, 3'd0, 2'b00, 1, 4'h0);
`ifndef WORD_CTRL_AUTOREINIT_EN
    check("t4_enw_count", enw_seen, 0);
    check("t4_done", done, 1);
`endif
    cycle(1, 3'd5, 2'b00, 0, 4'h0);

    // Instruction during RUN suppresses counting; then reset mid-RUN at count 2
    cycle(1, 3'd2, 2'b00, 0, 4'h8);
    cycle(1, 3'd4, 2'b00, 0, 4'h0);
    cycle(0, 3'd0, 2'b00, 1, 4'h0);
    cycle(1, 3'd1, 2'b00, 1, 4'h7);
    repeat (5) cycle(0, 3'd0, 2'b00, 1, 4'h0);
    check("t5_busy", busy, 1);
    mid_reset();
    repeat (3) cycle(0, 3'd0, 2'b00, 1, 4'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic stb;
      logic [2:0] ins;
      stb = ($urandom_range(0, 4) == 0);
      ins = 3'($urandom_range(0, 5));
      if (ins == 3'd5 && $urandom_range(0, 2) != 0) ins = 3'd4;
      cycle(stb, ins, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom));
      if (i == 1500) mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
